// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with a multi-cycle multiply/divide unit.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   a, b, aluctrl     operands and op select for the combinational ALU
//   out, zero         ALU result and equality flag (a == b)
//   md_start, md_op   multiply/divide request and op code
//   busy, done        MD in progress / one-cycle result pulse
//   hi, lo            HI/LO result registers
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluctrl,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SW   = $clog2(WIDTH);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Combinational ALU
    logic [SW-1:0] sh;

    always_comb begin
        sh  = a[SW-1:0];
        out = '0;
        case (aluctrl)
            4'd0:    out = a + b;
            4'd1:    out = a - b;
            4'd2:    out = a | b;
            4'd3:    out = a & b;
            4'd4:    out = a ^ b;
            4'd5:    out = ~(a | b);
            4'd6:    out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7:    out = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd8:    out = b << sh;
            4'd9:    out = b >> sh;
            4'd10:   out = $signed(b) >>> sh;
            4'd11:   out = b << (WIDTH/2);
            default: out = '0;
        endcase
    end

    assign zero = (a == b);

    // Multiply/divide unit
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] ra, rb;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Signed product via explicit sign extension; the low 2*WIDTH bits
    // of the unsigned product are the two's-complement signed product.
    assign prod_s = {{WIDTH{ra[WIDTH-1]}}, ra} * {{WIDTH{rb[WIDTH-1]}}, rb};
    assign prod_u = {{WIDTH{1'b0}}, ra} * {{WIDTH{1'b0}}, rb};
    assign quot_s = $signed(ra) / $signed(rb);
    assign rem_s  = $signed(ra) % $signed(rb);
    assign quot_u = ra / rb;
    assign rem_u  = ra % rb;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            2'd0: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            2'd1: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            2'd2: begin
                // Zero divisor and MOST_NEG / -1 are pinned explicitly.
                if (rb == '0) begin
                    res_hi = ra;
                    res_lo = ALL_ONES;
                end else if (ra == MOST_NEG && rb == ALL_ONES) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            default: begin
                if (rb == '0) begin
                    res_hi = ra;
                    res_lo = ALL_ONES;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            ra    <= '0;
            rb    <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                ra    <= a;
                                rb    <= b;
                                op_q  <= md_op[1:0];
                                cnt   <= md_op[1] ? CW'(DIV_CYCLES)
                                                  : CW'(MULT_CYCLES);
                                state <= RUN;
                            end
                            3'd4:    hi <= a;
                            3'd5:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Commit on the edge where the counter reaches zero;
                    // md_start is ignored for the whole run.
                    if (cnt == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (WIDTH=32).
// Drives inputs and samples outputs on the falling clock edge.
module tb_alu_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  aluctrl;
    logic [31:0] out;
    logic        zero;
    logic        md_start;
    logic [2:0]  md_op;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nchk;
    int nfail;

    alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .aluctrl(aluctrl),
        .out(out), .zero(zero), .md_start(md_start), .md_op(md_op),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp,
                       input string tag);
        aluctrl = op;
        a = va;
        b = vb;
        #1;
        check(tag, out, exp);
    endtask

    // Issue an MD op, optionally try an mthi during the run, then count
    // busy cycles and check the committed result and the done pulse.
    task automatic run_md(input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit inject, input string tag);
        int cyc;
        bit early_done;
        @(negedge clk);
        md_start = 1'b1;
        md_op = op;
        a = va;
        b = vb;
        @(negedge clk);
        md_start = inject;
        md_op = 3'd4;
        a = 32'h0000ABCD;
        b = 32'h00001111;
        cyc = 0;
        early_done = 1'b0;
        while (busy && cyc < 100) begin
            if (done) early_done = 1'b1;
            cyc++;
            @(negedge clk);
            md_start = 1'b0;
            md_op = 3'd7;
        end
        check({tag, " busy cycles"}, cyc, ncyc);
        check({tag, " done in run"}, {31'b0, early_done}, 32'd0);
        check({tag, " done pulse"}, {31'b0, done}, 32'd1);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        @(negedge clk);
        check({tag, " done cleared"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        bit saw;
        nchk = 0;
        nfail = 0;
        reset = 1'b1;
        md_start = 1'b0;
        md_op = 3'd0;
        aluctrl = 4'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        alu(4'd1, 32'd7, 32'd9, 32'hFFFFFFFE, "sub in reset");
        @(negedge clk);
        reset = 1'b0;

        alu(4'd0, 32'd7, 32'd9, 32'd16, "add");
        alu(4'd1, 32'd7, 32'd9, 32'hFFFFFFFE, "sub");
        alu(4'd2, 32'd7, 32'd9, 32'h0000000F, "or");
        alu(4'd3, 32'd7, 32'd9, 32'h00000001, "and");
        alu(4'd4, 32'd7, 32'd9, 32'h0000000E, "xor");
        alu(4'd5, 32'd7, 32'd9, 32'hFFFFFFF0, "nor");
        alu(4'd6, 32'd7, 32'd9, 32'd1, "slt");
        alu(4'd7, 32'd7, 32'd9, 32'd1, "sltu");
        alu(4'd6, 32'hFFFFFFFF, 32'd1, 32'd1, "slt neg");
        alu(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, "sltu big");
        alu(4'd8, 32'd4, 32'h80000001, 32'h00000010, "sll");
        alu(4'd9, 32'd4, 32'h80000000, 32'h08000000, "srl");
        alu(4'd10, 32'd4, 32'h80000000, 32'hF8000000, "sra");
        alu(4'd10, 32'h00000024, 32'h80000000, 32'hF8000000, "sra mask");
        alu(4'd11, 32'd0, 32'h00001234, 32'h12340000, "lui");
        alu(4'd12, 32'd7, 32'd9, 32'd0, "op12");
        alu(4'd15, 32'd7, 32'd9, 32'd0, "op15");
        a = 32'd5;
        b = 32'd5;
        #1;
        check("zero eq", {31'b0, zero}, 32'd1);
        b = 32'd6;
        #1;
        check("zero ne", {31'b0, zero}, 32'd0);

        run_md(3'd0, 32'hFFFFFFFE, 32'd3, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, "mult");
        run_md(3'd1, 32'hFFFFFFFE, 32'd3, 5,
               32'h00000002, 32'hFFFFFFFA, 1'b0, "multu");
        run_md(3'd2, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div");
        run_md(3'd3, 32'h00000055, 32'd0, 10,
               32'h00000055, 32'hFFFFFFFF, 1'b0, "divu0");
        run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h00000000, 32'h80000000, 1'b0, "divovf");
        run_md(3'd0, 32'd6, 32'd7, 5,
               32'h00000000, 32'd42, 1'b1, "mthi in run");

        // Reset on the third busy cycle
        @(negedge clk);
        md_start = 1'b1;
        md_op = 3'd0;
        a = 32'd100;
        b = 32'd100;
        @(negedge clk);
        md_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-rst busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        saw = 1'b0;
        repeat (6) begin
            if (done || busy) saw = 1'b1;
            @(negedge clk);
        end
        check("midrst quiet", {31'b0, saw}, 32'd0);
        check("midrst lo hold", lo, 32'd0);

        // mtlo in IDLE
        md_start = 1'b1;
        md_op = 3'd5;
        a = 32'd1;
        @(negedge clk);
        md_start = 1'b0;
        check("mtlo lo", lo, 32'd1);
        check("mtlo busy", {31'b0, busy}, 32'd0);
        check("mtlo done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("mtlo busy2", {31'b0, busy}, 32'd0);

        // mthi in IDLE, then no-op codes leave HI/LO alone
        md_start = 1'b1;
        md_op = 3'd4;
        a = 32'h0000BEEF;
        @(negedge clk);
        md_op = 3'd6;
        a = 32'h12345678;
        @(negedge clk);
        md_op = 3'd7;
        @(negedge clk);
        md_start = 1'b0;
        check("mthi hi", hi, 32'h0000BEEF);
        check("noop lo", lo, 32'd1);
        check("noop busy", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
